// File: rtl/can_fault_confinement_if.sv
// Signal bundle between the CAN protocol core and the fault-confinement engine.
interface can_fault_confinement_if #(parameter int CNT_W = 8);
  logic             sample_point;
  logic             rx_bit;
  logic             tx_active;
  logic             bit_error;
  logic             stuff_error;
  logic             crc_error;
  logic             form_error;
  logic             ack_error;
  logic             tx_err_exempt;
  logic             dominant_after_flag;
  logic             in_post_flag;
  logic             tx_ok;
  logic             rx_ok;
  logic             recover_req;
  logic [CNT_W:0]   tec;
  logic [CNT_W-1:0] rec;
  logic             error_active;
  logic             error_passive;
  logic             bus_off;
  logic             error_warning;
  logic             recovered;

  modport master (
    output sample_point, rx_bit, tx_active, bit_error, stuff_error, crc_error,
           form_error, ack_error, tx_err_exempt, dominant_after_flag,
           in_post_flag, tx_ok, rx_ok, recover_req,
    input  tec, rec, error_active, error_passive, bus_off, error_warning, recovered
  );

  modport slave (
    input  sample_point, rx_bit, tx_active, bit_error, stuff_error, crc_error,
           form_error, ack_error, tx_err_exempt, dominant_after_flag,
           in_post_flag, tx_ok, rx_ok, recover_req,
    output tec, rec, error_active, error_passive, bus_off, error_warning, recovered
  );
endinterface

// File: rtl/can_fault_confinement.sv
// CAN fault confinement: owns TEC/REC, node error state and bus-off recovery.
// state      | meaning
// ST_ACTIVE  | error active, both counters below passive limit
// ST_PASSIVE | error passive, a counter at/above passive limit
// ST_BUS_OFF | bus off, counters frozen, recovery counting when armed
module can_fault_confinement #(
  parameter int CNT_W         = 8,
  parameter int PASSIVE_LIMIT = 128,
  parameter int WARN_LIMIT    = 96,
  parameter int REC_RELOAD    = 119,
  parameter int RECOVERY_SEQS = 128,
  parameter int RECOVERY_BITS = 11,
  parameter bit AUTO_RECOVER  = 1'b1
) (
  input logic clk,
  input logic rst,
  can_fault_confinement_if.slave bus
);
  localparam int BIT_W = $clog2(RECOVERY_BITS + 1);
  localparam int SEQ_W = $clog2(RECOVERY_SEQS + 1);
  localparam logic [CNT_W:0]   TEC_MAX   = (CNT_W+1)'(1 << CNT_W);
  localparam logic [CNT_W:0]   TEC_PL    = (CNT_W+1)'(PASSIVE_LIMIT);
  localparam logic [CNT_W:0]   TEC_WL    = (CNT_W+1)'(WARN_LIMIT);
  localparam logic [CNT_W-1:0] REC_PL    = CNT_W'(PASSIVE_LIMIT);
  localparam logic [CNT_W-1:0] REC_WL    = CNT_W'(WARN_LIMIT);
  localparam logic [CNT_W-1:0] REC_RL    = CNT_W'(REC_RELOAD);
  localparam logic [CNT_W-1:0] REC_MAX   = '1;
  localparam logic [BIT_W-1:0] BITS_END  = BIT_W'(RECOVERY_BITS);
  localparam logic [SEQ_W-1:0] SEQS_LAST = SEQ_W'(RECOVERY_SEQS - 1);

  typedef enum logic [1:0] {ST_ACTIVE, ST_PASSIVE, ST_BUS_OFF} state_t;

  state_t           state;
  logic [CNT_W:0]   tec_q, tec_nxt;
  logic [CNT_W-1:0] rec_q, rec_nxt;
  logic [CNT_W+1:0] tec_sum;
  logic [CNT_W:0]   rec_sum;
  logic [4:0]       dom_run, dom_nxt, rec_add;
  logic [BIT_W-1:0] rcv_bits, bits_nxt;
  logic [SEQ_W-1:0] rcv_seqs;
  logic             armed, err_ev, post_hit, tx_inc, any_inc;
  logic             ea_q, ep_q, bo_q, recovered_q;

  always_comb begin
    err_ev   = bus.bit_error | bus.stuff_error | bus.crc_error | bus.form_error | bus.ack_error;
    dom_nxt  = dom_run + 5'd1;
    // Dominant run penalises at 14 and every 8 bits after; the counter folds 22 back to 14.
    post_hit = bus.sample_point & bus.in_post_flag & ~bus.rx_bit &
               ((dom_nxt == 5'd14) | (dom_nxt == 5'd22));
    tx_inc   = bus.tx_active & ((err_ev & ~bus.tx_err_exempt) | bus.dominant_after_flag | post_hit);
    rec_add  = 5'd0;
    if (!bus.tx_active)
      rec_add = {4'd0, err_ev} + (bus.dominant_after_flag ? 5'd8 : 5'd0) + (post_hit ? 5'd8 : 5'd0);
    any_inc  = tx_inc | (rec_add != 5'd0);
    tec_sum  = {1'b0, tec_q} + (CNT_W+2)'(8);
    rec_sum  = {1'b0, rec_q} + (CNT_W+1)'(rec_add);
    bits_nxt = rcv_bits + 1'b1;

    tec_nxt = tec_q;
    if (tx_inc)
      tec_nxt = (tec_sum > {1'b0, TEC_MAX}) ? TEC_MAX : tec_sum[CNT_W:0];
    else if (!any_inc && bus.tx_ok && tec_q != '0)
      tec_nxt = tec_q - 1'b1;

    rec_nxt = rec_q;
    if (rec_add != 5'd0)
      rec_nxt = rec_sum[CNT_W] ? REC_MAX : rec_sum[CNT_W-1:0];
    else if (!any_inc && bus.rx_ok) begin
      if (rec_q >= REC_PL)
        rec_nxt = REC_RL;
      else if (rec_q != '0)
        rec_nxt = rec_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_ACTIVE;
      tec_q       <= '0;
      rec_q       <= '0;
      dom_run     <= '0;
      rcv_bits    <= '0;
      rcv_seqs    <= '0;
      armed       <= 1'b0;
      ea_q        <= 1'b1;
      ep_q        <= 1'b0;
      bo_q        <= 1'b0;
      recovered_q <= 1'b0;
    end else begin
      recovered_q <= 1'b0;
      if (!bus.in_post_flag)
        dom_run <= '0;
      else if (bus.sample_point)
        dom_run <= bus.rx_bit ? 5'd0 : ((dom_nxt == 5'd22) ? 5'd14 : dom_nxt);

      case (state)
        ST_ACTIVE, ST_PASSIVE: begin
          tec_q <= tec_nxt;
          rec_q <= rec_nxt;
          if (tec_q >= TEC_MAX) begin
            state <= ST_BUS_OFF;
            ea_q  <= 1'b0;
            ep_q  <= 1'b0;
            bo_q  <= 1'b1;
            armed <= AUTO_RECOVER;
          end else if (tec_q >= TEC_PL || rec_q >= REC_PL) begin
            state <= ST_PASSIVE;
            ea_q  <= 1'b0;
            ep_q  <= 1'b1;
            bo_q  <= 1'b0;
          end else begin
            state <= ST_ACTIVE;
            ea_q  <= 1'b1;
            ep_q  <= 1'b0;
            bo_q  <= 1'b0;
          end
        end
        default: begin
          if (bus.recover_req)
            armed <= 1'b1;
          if (armed && bus.sample_point) begin
            if (!bus.rx_bit)
              rcv_bits <= '0;
            else if (bits_nxt == BITS_END) begin
              rcv_bits <= '0;
              if (rcv_seqs == SEQS_LAST) begin
                rcv_seqs    <= '0;
                armed       <= 1'b0;
                tec_q       <= '0;
                rec_q       <= '0;
                state       <= ST_ACTIVE;
                ea_q        <= 1'b1;
                bo_q        <= 1'b0;
                recovered_q <= 1'b1;
              end else
                rcv_seqs <= rcv_seqs + 1'b1;
            end else
              rcv_bits <= bits_nxt;
          end
        end
      endcase
    end
  end

  assign bus.tec           = tec_q;
  assign bus.rec           = rec_q;
  assign bus.error_active  = ea_q;
  assign bus.error_passive = ep_q;
  assign bus.bus_off       = bo_q;
  assign bus.recovered     = recovered_q;
  assign bus.error_warning = (state != ST_BUS_OFF) && (tec_q >= TEC_WL || rec_q >= REC_WL);
endmodule

// File: tb/tb_can_fault_confinement.sv
// Scenario bench for can_fault_confinement: expectations queued at stimulus, compared on output.
module tb_can_fault_confinement;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_fault_confinement_if #(.CNT_W(8)) bus ();

  can_fault_confinement #(
    .CNT_W(8), .PASSIVE_LIMIT(128), .WARN_LIMIT(96), .REC_RELOAD(119),
    .RECOVERY_SEQS(128), .RECOVERY_BITS(11), .AUTO_RECOVER(1'b0)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int fails  = 0;
  int exp_q[$];
  int exp;

  task automatic idle();
    bus.sample_point = 0; bus.rx_bit = 1; bus.tx_active = 0;
    bus.bit_error = 0; bus.stuff_error = 0; bus.crc_error = 0; bus.form_error = 0;
    bus.ack_error = 0; bus.tx_err_exempt = 0; bus.dominant_after_flag = 0;
    bus.in_post_flag = 0; bus.tx_ok = 0; bus.rx_ok = 0; bus.recover_req = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // kind: 0 bit, 1 stuff, 2 crc, 3 form, 4 ack
  task automatic err(input int n, input bit txa, input int kind);
    bus.tx_active = txa;
    repeat (n) begin
      bus.bit_error = (kind == 0); bus.stuff_error = (kind == 1); bus.crc_error = (kind == 2);
      bus.form_error = (kind == 3); bus.ack_error = (kind == 4);
      tick();
      bus.bit_error = 0; bus.stuff_error = 0; bus.crc_error = 0;
      bus.form_error = 0; bus.ack_error = 0;
    end
  endtask

  task automatic samp(input int n, input bit b, input bit post);
    bus.in_post_flag = post;
    repeat (n) begin
      bus.sample_point = 1; bus.rx_bit = b;
      tick();
    end
    bus.sample_point = 0; bus.rx_bit = 1;
  endtask

  task automatic enter_bus_off();
    err(32, 1, 0);
    tick();
    bus.recover_req = 1; tick(); bus.recover_req = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b0;
    err(3, 1, 0);
    exp_q.push_back(24);
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL pre_reset_tec: got %0d expected %0d", bus.tec, exp); end
    #2 rst = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(0);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL reset_tec: got %0d expected %0d", bus.tec, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL reset_rec: got %0d expected %0d", bus.rec, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0])
      begin fails++; $display("FAIL reset_state: got %b expected %b", {bus.error_active, bus.error_passive, bus.bus_off}, exp[2:0]); end
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_warning, bus.recovered} !== exp[1:0])
      begin fails++; $display("FAIL reset_warn_rcv: got %b expected %b", {bus.error_warning, bus.recovered}, exp[1:0]); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_tx_counters();
    do_reset();
    err(12, 1, 0); exp_q.push_back(96);
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0] || bus.error_warning !== 1'b1)
      begin fails++; $display("FAIL tec_warn: got tec %0d warn %b expected %0d warn 1", bus.tec, bus.error_warning, exp); end
    err(4, 1, 0); exp_q.push_back(128);
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL tec_128: got %0d expected %0d", bus.tec, exp); end
    tick(); exp_q.push_back(2);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0])
      begin fails++; $display("FAIL tx_passive: got %b expected %b", {bus.error_active, bus.error_passive, bus.bus_off}, exp[2:0]); end
    bus.tx_ok = 1; tick(); bus.tx_ok = 0; exp_q.push_back(127);
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL tec_127: got %0d expected %0d", bus.tec, exp); end
    tick(); exp_q.push_back(4);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0])
      begin fails++; $display("FAIL tx_active_back: got %b expected %b", {bus.error_active, bus.error_passive, bus.bus_off}, exp[2:0]); end
  endtask

  task automatic test_rx_counters();
    do_reset();
    err(127, 0, 3); exp_q.push_back(127);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL rec_127: got %0d expected %0d", bus.rec, exp); end
    err(1, 0, 3); exp_q.push_back(128);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL rec_128: got %0d expected %0d", bus.rec, exp); end
    tick(); exp_q.push_back(2);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0])
      begin fails++; $display("FAIL rx_passive: got %b expected %b", {bus.error_active, bus.error_passive, bus.bus_off}, exp[2:0]); end
    bus.rx_ok = 1; tick(); bus.rx_ok = 0; exp_q.push_back(119);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL rec_reload: got %0d expected %0d", bus.rec, exp); end
    tick(); exp_q.push_back(4);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0])
      begin fails++; $display("FAIL rx_active_back: got %b expected %b", {bus.error_active, bus.error_passive, bus.bus_off}, exp[2:0]); end
    do_reset();
    bus.rx_ok = 1; tick(); bus.rx_ok = 0; exp_q.push_back(0);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL rec_zero_ok: got %0d expected %0d", bus.rec, exp); end
  endtask

  task automatic test_post_flag();
    do_reset();
    bus.tx_active = 0;
    samp(13, 0, 1); exp_q.push_back(0);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL dom_13: got %0d expected %0d", bus.rec, exp); end
    samp(1, 0, 1); exp_q.push_back(8);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL dom_14: got %0d expected %0d", bus.rec, exp); end
    samp(8, 0, 1); exp_q.push_back(16);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL dom_22: got %0d expected %0d", bus.rec, exp); end
    samp(1, 1, 1); samp(13, 0, 1); exp_q.push_back(16);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL dom_restart: got %0d expected %0d", bus.rec, exp); end
    bus.in_post_flag = 0; tick();
    bus.tx_active = 1;
    samp(14, 0, 1); exp_q.push_back(8); exp_q.push_back(16);
    bus.in_post_flag = 0;
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL dom_tx_tec: got %0d expected %0d", bus.tec, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL dom_tx_rec: got %0d expected %0d", bus.rec, exp); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    err(5, 1, 0);
    bus.bit_error = 1; bus.crc_error = 1; bus.tx_ok = 1; tick();
    bus.bit_error = 0; bus.crc_error = 0; bus.tx_ok = 0; exp_q.push_back(48);
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL multi_err_tx_ok: got %0d expected %0d", bus.tec, exp); end
    bus.bit_error = 1; bus.dominant_after_flag = 1; tick();
    bus.bit_error = 0; bus.dominant_after_flag = 0; exp_q.push_back(56);
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL daf_tx_once: got %0d expected %0d", bus.tec, exp); end
    bus.bit_error = 1; bus.tx_err_exempt = 1; tick();
    bus.bit_error = 0; bus.tx_err_exempt = 0; exp_q.push_back(56); exp_q.push_back(0);
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL exempt_tec: got %0d expected %0d", bus.tec, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL exempt_rec: got %0d expected %0d", bus.rec, exp); end
    bus.tx_active = 0; bus.stuff_error = 1; bus.ack_error = 1; bus.dominant_after_flag = 1; tick();
    bus.stuff_error = 0; bus.ack_error = 0; bus.dominant_after_flag = 0; exp_q.push_back(9);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL daf_rx: got %0d expected %0d", bus.rec, exp); end
    bus.rx_ok = 1; tick(); bus.rx_ok = 0; exp_q.push_back(8);
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL rx_ok_dec: got %0d expected %0d", bus.rec, exp); end
  endtask

  task automatic test_bus_off();
    do_reset();
    err(32, 1, 0); exp_q.push_back(256);
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL tec_256: got %0d expected %0d", bus.tec, exp); end
    err(1, 1, 0); exp_q.push_back(1);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0] || bus.error_warning !== 1'b0 || bus.tec !== 9'd256)
      begin fails++; $display("FAIL bus_off_entry: got %b warn %b tec %0d expected %b warn 0 tec 256", {bus.error_active, bus.error_passive, bus.bus_off}, bus.error_warning, bus.tec, exp[2:0]); end
    err(1, 0, 3); bus.tx_ok = 1; bus.rx_ok = 1; tick(); bus.tx_ok = 0; bus.rx_ok = 0;
    exp_q.push_back(256); exp_q.push_back(0);
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0]) begin fails++; $display("FAIL frozen_tec: got %0d expected %0d", bus.tec, exp); end
    exp = exp_q.pop_front(); checks++;
    if (bus.rec !== exp[7:0]) begin fails++; $display("FAIL frozen_rec: got %0d expected %0d", bus.rec, exp); end
    samp(1408, 1, 0); exp_q.push_back(1);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0])
      begin fails++; $display("FAIL no_req_stays: got %b expected %b", {bus.error_active, bus.error_passive, bus.bus_off}, exp[2:0]); end
    bus.recover_req = 1; tick(); bus.recover_req = 0;
    samp(1407, 1, 0); exp_q.push_back(1);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0] || bus.recovered !== 1'b0)
      begin fails++; $display("FAIL pre_recovery: got %b rcv %b expected %b rcv 0", {bus.error_active, bus.error_passive, bus.bus_off}, bus.recovered, exp[2:0]); end
    samp(1, 1, 0); exp_q.push_back(4); exp_q.push_back(0);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0] || bus.recovered !== 1'b1)
      begin fails++; $display("FAIL recovery_exit: got %b rcv %b expected %b rcv 1", {bus.error_active, bus.error_passive, bus.bus_off}, bus.recovered, exp[2:0]); end
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0] || bus.rec !== 8'd0) begin fails++; $display("FAIL recovery_counters: got tec %0d rec %0d expected %0d and 0", bus.tec, bus.rec, exp); end
    tick(); exp_q.push_back(0);
    exp = exp_q.pop_front(); checks++;
    if (bus.recovered !== exp[0]) begin fails++; $display("FAIL recovered_pulse: got %b expected %b", bus.recovered, exp[0]); end
  endtask

  task automatic test_mid_recovery();
    do_reset();
    enter_bus_off();
    samp(11, 1, 0); samp(10, 1, 0); samp(1, 0, 0);
    samp(127*11 - 1, 1, 0); exp_q.push_back(1);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0])
      begin fails++; $display("FAIL dominant_clears_bits: got %b expected %b", {bus.error_active, bus.error_passive, bus.bus_off}, exp[2:0]); end
    samp(1, 1, 0); exp_q.push_back(1);
    exp = exp_q.pop_front(); checks++;
    if (bus.recovered !== exp[0] || bus.error_active !== 1'b1)
      begin fails++; $display("FAIL seq_kept_exit: got rcv %b active %b expected 1 1", bus.recovered, bus.error_active); end
    enter_bus_off();
    samp(500, 1, 0);
    #2 rst = 1'b1;
    exp_q.push_back(0); exp_q.push_back(4);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (bus.tec !== exp[8:0] || bus.rec !== 8'd0) begin fails++; $display("FAIL mid_rst_counters: got tec %0d rec %0d expected %0d and 0", bus.tec, bus.rec, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0])
      begin fails++; $display("FAIL mid_rst_state: got %b expected %b", {bus.error_active, bus.error_passive, bus.bus_off}, exp[2:0]); end
    @(negedge clk); rst = 1'b0;
    enter_bus_off();
    samp(1407, 1, 0); exp_q.push_back(1);
    exp = exp_q.pop_front(); checks++;
    if ({bus.error_active, bus.error_passive, bus.bus_off} !== exp[2:0])
      begin fails++; $display("FAIL rst_cleared_seqs: got %b expected %b", {bus.error_active, bus.error_passive, bus.bus_off}, exp[2:0]); end
    samp(1, 1, 0); exp_q.push_back(1);
    exp = exp_q.pop_front(); checks++;
    if (bus.recovered !== exp[0]) begin fails++; $display("FAIL post_rst_exit: got %b expected %b", bus.recovered, exp[0]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_tx_counters();
    test_rx_counters();
    test_post_flag();
    test_same_cycle();
    test_bus_off();
    test_mid_recovery();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
